// File: rtl/polar_entity_mapper.sv
// rtl/polar_entity_mapper.sv - polar-to-screen entity mapper with double-buffered positions and per-pixel hit query
module polar_entity_mapper #(
  parameter int N_ENT      = 4,
  parameter int ANGLE_BITS = 5,
  parameter int DIST_W     = 9,
  parameter int COORD_W    = 10,
  parameter int FRAC       = 6,
  parameter int CENTER_X   = 399,
  parameter int CENTER_Y   = 239,
  parameter int HALF_SIZE  = 18,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [3:0]            upd_idx,
  input  logic [DIST_W-1:0]     upd_distance,
  input  logic [ANGLE_BITS-1:0] upd_angle,
  output logic                  upd_done,
  output logic                  upd_err,
  input  logic                  frame_start,
  input  logic [COORD_W-1:0]    hc,
  input  logic [COORD_W-1:0]    vc,
  output logic                  hit,
  output logic [3:0]            hit_idx,
  output logic [COORD_W-1:0]    ent_x,
  output logic [COORD_W-1:0]    ent_y
);

  localparam int QTR = 1 << (ANGLE_BITS - 2);
  localparam int IW  = ANGLE_BITS - 1;
  localparam int LW  = FRAC + 1;
  localparam int PW  = DIST_W + FRAC + 1;
  localparam int MW  = DIST_W + 1;
  localparam int XW  = COORD_W + 2;

  localparam logic signed [XW-1:0] CX_S = XW'(CENTER_X);
  localparam logic signed [XW-1:0] CY_S = XW'(CENTER_Y);
  localparam logic signed [XW-1:0] HS_S = XW'(HALF_SIZE);
  localparam logic signed [XW-1:0] SW_S = XW'(SCREEN_W);
  localparam logic signed [XW-1:0] SH_S = XW'(SCREEN_H);
  localparam logic [4:0]           N_ENT_V = 5'(N_ENT);

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_MUL, ST_WRITE} state_t;

  // Elaboration-time sine of k quarter-steps, scaled by 2^FRAC and rounded to nearest.
  function automatic int sin_q(input int k);
    real x, term, sum;
    x    = 1.5707963267948966 * $itor(k) / $itor(QTR);
    term = x;
    sum  = x;
    for (int n = 1; n < 10; n++) begin
      term = -term * x * x / $itor((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return $rtoi(sum * $itor(1 << FRAC) + 0.5);
  endfunction

  logic [LW-1:0] lut [QTR+1];
  for (genvar g = 0; g <= QTR; g++) begin : g_lut
    assign lut[g] = LW'(sin_q(g));
  end

  state_t                  state;
  logic [DIST_W-1:0]       dist_q;
  logic [ANGLE_BITS-1:0]   ang_q;
  logic [3:0]              idx_q;
  logic [LW-1:0]           lutc_q, luts_q;
  logic                    negc_q, negs_q;
  logic [MW-1:0]           magx_q, magy_q;

  logic signed [XW-1:0]    sh_x [N_ENT];
  logic signed [XW-1:0]    sh_y [N_ENT];
  logic                    sh_vis [N_ENT];
  logic signed [XW-1:0]    act_x [N_ENT];
  logic signed [XW-1:0]    act_y [N_ENT];
  logic                    act_vis [N_ENT];

  logic [IW-1:0]           cos_i, sin_i, rem;
  logic                    cos_n, sin_n;
  logic signed [XW-1:0]    mx, my, new_x, new_y;
  logic                    new_vis, idx_err;

  assign upd_ready = (state == ST_IDLE) && RST_N;
  assign idx_err   = {1'b0, idx_q} >= N_ENT_V;

  // Fold the angle into a quarter-wave index plus sign for cos and sin.
  always_comb begin
    rem   = IW'(ang_q[ANGLE_BITS-3:0]);
    cos_i = '0;
    sin_i = '0;
    cos_n = 1'b0;
    sin_n = 1'b0;
    case (ang_q[ANGLE_BITS-1 -: 2])
      2'd0: begin cos_i = IW'(QTR) - rem; sin_i = rem; end
      2'd1: begin cos_i = rem; cos_n = 1'b1; sin_i = IW'(QTR) - rem; end
      2'd2: begin cos_i = IW'(QTR) - rem; cos_n = 1'b1; sin_i = rem; sin_n = 1'b1; end
      default: begin cos_i = rem; sin_i = IW'(QTR) - rem; sin_n = 1'b1; end
    endcase
  end

  // Screen position and visibility of the entry being written (screen y grows downward).
  always_comb begin
    mx      = XW'(magx_q);
    my      = XW'(magy_q);
    new_x   = negc_q ? (CX_S - mx) : (CX_S + mx);
    new_y   = negs_q ? (CY_S + my) : (CY_S - my);
    new_vis = (new_x >= HS_S) && (new_x + HS_S <= SW_S) &&
              (new_y >= HS_S) && (new_y + HS_S <= SH_S);
  end

  // Update FSM: capture, LUT lookup, multiply, shadow write; done/err registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      dist_q   <= '0;
      ang_q    <= '0;
      idx_q    <= '0;
      lutc_q   <= '0;
      luts_q   <= '0;
      negc_q   <= 1'b0;
      negs_q   <= 1'b0;
      magx_q   <= '0;
      magy_q   <= '0;
      upd_done <= 1'b0;
      upd_err  <= 1'b0;
      for (int i = 0; i < N_ENT; i++) begin
        sh_x[i]   <= CX_S;
        sh_y[i]   <= CY_S;
        sh_vis[i] <= 1'b0;
      end
    end else begin
      upd_done <= 1'b0;
      upd_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (upd_valid) begin
            dist_q <= upd_distance;
            ang_q  <= upd_angle;
            idx_q  <= upd_idx;
            state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          lutc_q <= lut[cos_i];
          luts_q <= lut[sin_i];
          negc_q <= cos_n;
          negs_q <= sin_n;
          state  <= ST_MUL;
        end
        ST_MUL: begin
          magx_q <= MW'((PW'(dist_q) * PW'(lutc_q)) >> FRAC);
          magy_q <= MW'((PW'(dist_q) * PW'(luts_q)) >> FRAC);
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          upd_done <= 1'b1;
          upd_err  <= idx_err;
          for (int i = 0; i < N_ENT; i++) begin
            if (!idx_err && idx_q == 4'(i)) begin
              sh_x[i]   <= new_x;
              sh_y[i]   <= new_y;
              sh_vis[i] <= new_vis;
            end
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Frame commit: whole shadow set becomes the active set on one edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_ENT; i++) begin
        act_x[i]   <= CX_S;
        act_y[i]   <= CY_S;
        act_vis[i] <= 1'b0;
      end
    end else if (frame_start) begin
      for (int i = 0; i < N_ENT; i++) begin
        act_x[i]   <= sh_x[i];
        act_y[i]   <= sh_y[i];
        act_vis[i] <= sh_vis[i];
      end
    end
  end

  logic signed [XW-1:0] hc_s, vc_s;
  logic                 p_hit;
  logic [3:0]           p_idx;
  logic [COORD_W-1:0]   p_ex, p_ey;

  // Box test against every active entity; scanning downward leaves the lowest index.
  always_comb begin
    hc_s  = XW'(hc);
    vc_s  = XW'(vc);
    p_hit = 1'b0;
    p_idx = '0;
    p_ex  = '0;
    p_ey  = '0;
    for (int i = N_ENT - 1; i >= 0; i--) begin
      if (act_vis[i] &&
          hc_s >= act_x[i] - HS_S && hc_s < act_x[i] + HS_S &&
          vc_s >= act_y[i] - HS_S && vc_s < act_y[i] + HS_S) begin
        p_hit = 1'b1;
        p_idx = 4'(i);
        p_ex  = COORD_W'(hc_s - act_x[i] + HS_S);
        p_ey  = COORD_W'(vc_s - act_y[i] + HS_S);
      end
    end
  end

  // Register the pixel answer for a fixed one-cycle latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hit     <= 1'b0;
      hit_idx <= '0;
      ent_x   <= '0;
      ent_y   <= '0;
    end else begin
      hit     <= p_hit;
      hit_idx <= p_idx;
      ent_x   <= p_ex;
      ent_y   <= p_ey;
    end
  end

endmodule

// File: tb/tb_polar_entity_mapper.sv
// tb/tb_polar_entity_mapper.sv - scoreboard bench for polar_entity_mapper
module tb_polar_entity_mapper;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic [3:0] upd_idx = '0;
  logic [8:0] upd_distance = '0;
  logic [4:0] upd_angle = '0;
  logic       upd_done, upd_err;
  logic       frame_start = 1'b0;
  logic [9:0] hc = '0, vc = '0;
  logic       hit;
  logic [3:0] hit_idx;
  logic [9:0] ent_x, ent_y;

  polar_entity_mapper dut (
    .CLK(CLK), .RST_N(RST_N),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx),
    .upd_distance(upd_distance), .upd_angle(upd_angle),
    .upd_done(upd_done), .upd_err(upd_err), .frame_start(frame_start),
    .hc(hc), .vc(vc), .hit(hit), .hit_idx(hit_idx), .ent_x(ent_x), .ent_y(ent_y)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic err; int idx; int d; int ang; } upd_t;
  typedef struct { logic h; int idx; int ex; int ey; } pix_t;

  upd_t upd_q[$];
  pix_t pix_q[$];
  int   checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  int   sx[4], sy[4], ax[4], ay[4];
  bit   sv[4], av[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      sx[i] = 399; sy[i] = 239; sv[i] = 0;
      ax[i] = 399; ay[i] = 239; av[i] = 0;
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < 4; i++) begin
      ax[i] = sx[i]; ay[i] = sy[i]; av[i] = sv[i];
    end
  endtask

  function automatic int lmag(input real v);
    real a;
    a = (v < 0.0) ? -v : v;
    return $rtoi(a * 64.0 + 0.5);
  endfunction

  task automatic model_write(input upd_t u);
    real th, c, s;
    int  mx, my, x, y;
    if (u.err) return;
    th = 2.0 * 3.14159265358979 * $itor(u.ang) / 32.0;
    c  = $cos(th);
    s  = $sin(th);
    mx = (u.d * lmag(c)) / 64;
    my = (u.d * lmag(s)) / 64;
    x  = (c < 0.0) ? 399 - mx : 399 + mx;
    y  = (s < 0.0) ? 239 + my : 239 - my;
    sx[u.idx] = x;
    sy[u.idx] = y;
    sv[u.idx] = (x >= 18) && (x + 18 <= 640) && (y >= 18) && (y + 18 <= 480);
  endtask

  // One clock: compare pending pixel expectation and any update completion.
  task automatic step();
    pix_t p;
    upd_t u;
    @(negedge CLK);
    cyc++;
    if (pix_q.size() > 0) begin
      p = pix_q.pop_front();
      chk("hit", hit, p.h);
      chk("hit_idx", hit_idx, p.idx);
      chk("ent_x", ent_x, p.ex);
      chk("ent_y", ent_y, p.ey);
    end
    if (upd_done) begin
      done_cnt++;
      if (upd_q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        u = upd_q.pop_front();
        chk("upd_err", upd_err, u.err);
        model_write(u);
      end
    end
  endtask

  task automatic pix(input int h, input int v);
    pix_t p;
    hc = 10'(h);
    vc = 10'(v);
    p = '{h: 1'b0, idx: 0, ex: 0, ey: 0};
    for (int i = 3; i >= 0; i--) begin
      if (av[i] && h >= ax[i] - 18 && h < ax[i] + 18 && v >= ay[i] - 18 && v < ay[i] + 18) begin
        p.h = 1'b1; p.idx = i;
        p.ex = (h - ax[i] + 18) & 10'h3ff;
        p.ey = (v - ay[i] + 18) & 10'h3ff;
      end
    end
    pix_q.push_back(p);
    step();
  endtask

  task automatic upd(input int idx, input int d, input int ang, input bit fs_at_write);
    int t, n, d0;
    t = 0;
    while (!upd_ready && t < 20) begin step(); t++; end
    chk("ready_wait", upd_ready, 1);
    upd_valid = 1'b1;
    upd_idx = 4'(idx); upd_distance = 9'(d); upd_angle = 5'(ang);
    upd_q.push_back('{err: (idx >= 4), idx: idx, d: d, ang: ang});
    d0 = done_cnt;
    step();
    upd_valid = 1'b0;
    n = 1;
    chk("busy_ready", upd_ready, 0);
    while (done_cnt == d0 && n < 10) begin
      if (fs_at_write && n == 3) begin
        frame_start = 1'b1;
        model_commit();
      end
      step();
      frame_start = 1'b0;
      n++;
    end
    chk("upd_latency", n, 4);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    model_commit();
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int d0, c0, t1, t2;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_ready", upd_ready, 0);
    chk("rst_hit", hit, 0);
    chk("rst_done", upd_done, 0);
    chk("rst_err", upd_err, 0);
    RST_N = 1'b1;
    step();
    chk("ready_after_rst", upd_ready, 1);
    pix(399, 239);

    // basic placement, box corner and right edge exclusion
    upd(0, 100, 0, 0);
    frame();
    pix(481, 221);
    pix(517, 221);
    pix(499, 239);

    // cardinal and diagonal directions
    upd(0, 50, 8, 0);
    frame();
    pix(381, 171);
    pix(399, 189);
    upd(1, 100, 4, 0);
    upd(2, 100, 20, 0);
    frame();
    pix(451, 151);
    pix(346, 326);
    pix(347, 309);

    // off-screen entity never hits
    upd(3, 400, 16, 0);
    frame();
    pix(0, 239);
    pix(16, 239);
    pix(5, 230);

    // overlap priority and bad index
    upd(0, 0, 0, 0);
    upd(1, 0, 0, 0);
    frame();
    pix(399, 239);
    upd(7, 50, 3, 0);
    frame();
    pix(399, 239);
    pix(420, 239);

    // shadow isolation and commit coincident with write
    upd(2, 200, 12, 0);
    pix(259, 99);
    upd(3, 150, 28, 1);
    pix(504, 344);
    pix(259, 99);
    frame();
    pix(504, 344);

    // reset during an in-flight update
    hc = 10'd399; vc = 10'd239;
    upd_valid = 1'b1; upd_idx = 4'd1; upd_distance = 9'd100; upd_angle = 5'd0;
    step();
    upd_valid = 1'b0;
    step();
    RST_N = 1'b0;
    model_reset();
    upd_q.delete();
    pix_q.delete();
    #1;
    chk("midrst_ready", upd_ready, 0);
    chk("midrst_done", upd_done, 0);
    chk("midrst_hit", hit, 0);
    chk("midrst_hit_idx", hit_idx, 0);
    chk("midrst_ent_x", ent_x, 0);
    chk("midrst_ent_y", ent_y, 0);
    step();
    RST_N = 1'b1;
    d0 = done_cnt;
    repeat (6) step();
    chk("no_done_after_rst", done_cnt, d0);
    pix(399, 239);
    pix(499, 239);
    frame();
    pix(399, 239);

    // back-to-back updates with valid held high
    upd_valid = 1'b1; upd_idx = 4'd0; upd_distance = 9'd100; upd_angle = 5'd0;
    upd_q.push_back('{err: 1'b0, idx: 0, d: 100, ang: 0});
    c0 = cyc; t1 = -1; t2 = -1;
    d0 = done_cnt;
    for (int k = 0; k < 12; k++) begin
      step();
      if (t1 < 0 && done_cnt == d0 + 1) begin
        t1 = cyc;
        upd_idx = 4'd1; upd_distance = 9'd50; upd_angle = 5'd8;
        upd_q.push_back('{err: 1'b0, idx: 1, d: 50, ang: 8});
      end else if (t1 >= 0 && cyc == t1 + 1) begin
        upd_valid = 1'b0;
      end
      if (t2 < 0 && done_cnt == d0 + 2) t2 = cyc;
    end
    upd_valid = 1'b0;
    chk("b2b_first", t1 - c0, 4);
    chk("b2b_gap", t2 - t1, 4);
    frame();
    pix(499, 239);
    pix(399, 189);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
